// File: rtl/sync_debounce.sv
// sync_debounce: conditions a raw asynchronous level for use in the clk domain.
//   A flop-chain synchronizer feeds a four-state debounce FSM. A new level is
//   accepted only after DEBOUNCE_CYCLES consecutive synchronized samples agree.
//   The outputs are a registered clean level and one-cycle rise/fall pulses.
//
// Optional feature: define SYNC_DEBOUNCE_GLITCH_CNT_EN to add glitch_cnt.
//   glitch_cnt is a saturating 8-bit count of aborted (rejected) transitions.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   raw asynchronous input
//   level      out  debounced, registered level
//   rise       out  one-cycle pulse on level 0->1
//   fall       out  one-cycle pulse on level 1->0
//   glitch_cnt out  [7:0] rejected-transition count (only with the macro)
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       level,
  output logic       rise,
  output logic       fall
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;

  // Plain shift chain; nothing between stages so each flop can resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StStableLo;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      StStableLo: begin
        if (w_sync_q) begin
          w_state_nxt = StWaitHi;
          w_cnt_nxt   = LP_CNT_ONE;
        end
      end
      StWaitHi: begin
        if (!w_sync_q) begin
          w_state_nxt = StStableLo;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = StStableHi;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      StStableHi: begin
        if (!w_sync_q) begin
          w_state_nxt = StWaitLo;
          w_cnt_nxt   = LP_CNT_ONE;
        end
      end
      StWaitLo: begin
        if (w_sync_q) begin
          w_state_nxt = StStableHi;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = StStableLo;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = StStableLo;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_cnt;

  // A glitch is a WAIT state aborted because the sample reverted to the stable level.
  assign w_glitch = ((r_state == StWaitHi) && !w_sync_q) ||
                    ((r_state == StWaitLo) &&  w_sync_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce with directed scenarios and a randomized
// run compared against a run-length reference model of the debounce rules.
module tb_sync_debounce;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic din   = 1'b0;
  logic level;
  logic rise;
  logic fall;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  sync_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: din history delayed by S edges, plus the length of the
  // current run of samples that disagree with the accepted level.
  bit hist[$];
  bit m_level;
  bit m_rise;
  bit m_fall;
  int m_run;
  int m_glitch;

  task automatic model_reset();
    hist.delete();
    m_level  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  // Drive din for one cycle, advance the model over the edge, settle 1 time unit.
  task automatic tick(input bit d);
    bit s;
    din = d;
    @(posedge clk);
    s = (hist.size() == S) ? hist[0] : 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_rise  = s;
        m_fall  = !s;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    hist.push_back(d);
    if (hist.size() > S) void'(hist.pop_front());
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({level, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 000", {level, rise, fall});
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_glitch_cnt: got %0d want 0", glitch_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b1);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_level: got %b want 1", level);
    end
    // Mid-cycle reset with din held high: outputs drop before the next edge.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({level, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: got %b want 000", {level, rise, fall});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      n_cmp++;
      if ({level, rise, fall} !== {(i >= 6), (i == 6), 1'b0}) begin
        n_bad++;
        $display("FAIL release_rise edge %0d: got lvl/rise/fall=%b want %b", i,
                 {level, rise, fall}, {(i >= 6), (i == 6), 1'b0});
      end
    end
  endtask

  task automatic test_clean_fall();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0);
      n_cmp++;
      if ({level, rise, fall} !== {(i < 6), 1'b0, (i == 6)}) begin
        n_bad++;
        $display("FAIL clean_fall edge %0d: got lvl/rise/fall=%b want %b", i,
                 {level, rise, fall}, {(i < 6), 1'b0, (i == 6)});
      end
    end
  endtask

  task automatic test_clean_rise();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      n_cmp++;
      if ({level, rise, fall} !== {(i >= 6), (i == 6), 1'b0}) begin
        n_bad++;
        $display("FAIL clean_rise edge %0d: got lvl/rise/fall=%b want %b", i,
                 {level, rise, fall}, {(i >= 6), (i == 6), 1'b0});
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) tick(1'b0);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_pre_level: got %b want 0", level);
    end
    for (int i = 0; i < 11; i++) begin
      tick(i < 3);
      n_cmp++;
      if ({level, rise, fall} !== 3'b000) begin
        n_bad++;
        $display("FAIL glitch_reject cycle %0d: got lvl/rise/fall=%b want 000", i,
                 {level, rise, fall});
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL glitch_cnt_one: got %0d want 1", glitch_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) tick(1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({level, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_wait_reset: got %b want 000", {level, rise, fall});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      n_cmp++;
      if ({level, rise, fall} !== {(i >= 6), (i == 6), 1'b0}) begin
        n_bad++;
        $display("FAIL mid_wait_requal edge %0d: got lvl/rise/fall=%b want %b", i,
                 {level, rise, fall}, {(i >= 6), (i == 6), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    bit d;
    int len;
    for (int r = 0; r < 300; r++) begin
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * D);
      for (int k = 0; k < len; k++) begin
        tick(d);
        n_cmp++;
        if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
          n_bad++;
          $display("FAIL random run %0d: got lvl/rise/fall=%b want %b", r,
                   {level, rise, fall}, {m_level, m_rise, m_fall});
        end
        n_cmp++;
        if ((rise & fall) !== 1'b0) begin
          n_bad++;
          $display("FAIL random_exclusive run %0d: got rise&fall=%b want 0", r, rise & fall);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 8'(m_glitch)) begin
          n_bad++;
          $display("FAIL random_glitch_cnt run %0d: got %0d want %0d", r, glitch_cnt, m_glitch);
        end
`endif
      end
    end
  endtask

  task automatic test_saturation();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 300; p++) begin
      for (int k = 0; k < 8; k++) begin
        tick(k < 3);
        n_cmp++;
        if ({level, rise, fall} !== 3'b000) begin
          n_bad++;
          $display("FAIL saturation_level pulse %0d: got lvl/rise/fall=%b want 000", p,
                   {level, rise, fall});
        end
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL saturation_cnt: got %0d want 255", glitch_cnt);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_glitch();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
